lcd_arbiter: RTL and testbench
==============================

# lcd_arbiter

Shares the single HD44780 character-LCD bus between two command requesters: CPU-mapped LCD port (requester 0) and the debug/status writer (requester 1). Round-robin arbitration; sequences each command through setup, enable pulse and busy-wait intervals in CLOCK_50 cycles. Optional power-on init sequence. Sits between the requesters and the board LCD pins, replacing free-running per-writer enable generation.

## Interface
- T_SETUP, 2, cycles RS/DATA stable before LCD_EN rises
- T_PULSE, 12, cycles LCD_EN high (240 ns at 50 MHz)
- T_SHORT, 2000, post-pulse wait for ordinary commands/data (40 us)
- T_LONG, 82000, post-pulse wait for clear/home (1.64 ms)
- T_POWERUP, 750000, power-on delay before init (15 ms)
- CLOCK_50  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high
- REQ0 / REQ1  in  1  command request, held until ACK
- RS0 / RS1  in  1  register select of pending command (1 = data)
- DATA0 / DATA1  in  8  byte of pending command
- ACK0 / ACK1  out  1  one-cycle pulse: command latched
- BUSY  out  1  arbiter not in IDLE, or init incomplete
- INIT_DONE  out  1  init sequence finished
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  constant 0 (write-only)
- LCD_DATA  out  8  LCD data bus

## Operation
- States: PWRUP, INIT, IDLE, SETUP, PULSE, WAIT. One down-counter (≥17 bits) shared by all timed states.
- PWRUP: count T_POWERUP, then INIT. INIT: load next init ROM byte (RS=0): 0x38, 0x0C, 0x01, 0x06; go SETUP. After the 4th command's WAIT, INIT_DONE=1, go IDLE.
- IDLE: if any REQ, pick winner, latch {RS,DATA} into output regs, pulse winner ACK, go SETUP. No REQ: stay.
- Arbitration: only one requesting → grant it. Both → grant the one not granted last. Last-grant pointer resets to 1 (requester 0 wins first tie). Init commands do not move the pointer.
- SETUP: T_SETUP cycles, EN=0. PULSE: T_PULSE cycles, EN=1. WAIT: EN=0, T_LONG if latched RS=0 and DATA[7:2]==0 (clear/home), else T_SHORT; then IDLE (or INIT while init pending).
- LCD_RS/LCD_DATA hold the latched value from latch through end of WAIT and into IDLE until next latch.
- REQ seen high in the cycle after ACK is a new command; requester must drop REQ or change data on ACK.
- REQ during non-IDLE states ignored until IDLE; requests never lost while held.
- BUSY = (state != IDLE) | !INIT_DONE.

## Timing
- Reset (async, immediate): LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, ACK0=ACK1=0, INIT_DONE=0, BUSY=1, state PWRUP, pointer=1.
- ACK in IDLE cycle k; LCD_EN high in cycles k+1+T_SETUP … k+T_SETUP+T_PULSE; IDLE re-entered cycle k+1+T_SETUP+T_PULSE+Twait; earliest next ACK in that cycle.
- Back-to-back same requester at full rate: one command per 1+T_SETUP+T_PULSE+Twait cycles.
- RESET mid-pulse: LCD_EN falls immediately; in-flight command discarded, no ACK; full power-up/init restarts.
- Counter reload takes effect on state entry; no off-by-one across state boundaries (each timed state lasts exactly its parameter, parameters ≥1).

## Configuration
- LCD_ARB_AUTO_INIT_EN defined: PWRUP/INIT present as above; requesters blocked until INIT_DONE.
- Undefined: PWRUP/INIT removed; reset state IDLE, INIT_DONE tied 1, BUSY reset value 0; requesters own display initialisation.

## Test plan
(Sim params: T_SETUP=2, T_PULSE=3, T_SHORT=5, T_LONG=20, T_POWERUP=10.)
- Reset with macro on, no REQ → EN pulses 4×, LCD_DATA 0x38,0x0C,0x01,0x06; 0x01 wait 20 cycles, others 5; INIT_DONE rises after last; no ACK.
- After init, REQ0 with RS0=1, DATA0=0x41 → ACK0 one cycle, EN high 3 cycles starting 3 cycles after ACK, LCD_RS=1, LCD_DATA=0x41, IDLE 5 cycles after EN falls.
- REQ0 and REQ1 held continuously, distinct data → grants alternate 0,1,0,1; first tie to 0; each ACK exactly 1 cycle.
- REQ1 RS=0 DATA=0x02 → wait 20 cycles; DATA=0x80 → wait 5 cycles.
- RESET asserted during PULSE → LCD_EN 0 same cycle, no ACK, power-up delay 10 then init rerun.
- Macro off: reset → BUSY=0, INIT_DONE=1, REQ0 acknowledged in first IDLE cycle, no init bytes emitted.

Source files
------------

// File: rtl/lcd_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_arbiter
//
// Shares one HD44780 character-LCD bus between two command requesters
// (0 = CPU-mapped LCD port, 1 = debug/status writer). Requests are granted
// round-robin. Each command goes through three timed phases: RS/DATA setup,
// an enable pulse, and a busy-wait. The busy-wait is long for clear/home and
// short for everything else. All timing is counted in CLOCK_50 cycles.
//
// Optional feature macro: LCD_ARB_AUTO_INIT_EN
//   defined   : power-on delay, then a 4-command init sequence
//               (0x38, 0x0C, 0x01, 0x06). Requesters wait for INIT_DONE.
//   undefined : the block resets straight into IDLE and INIT_DONE is tied
//               high. The requesters initialise the display themselves.
//
// Ports
//   CLOCK_50         in   system clock, 50 MHz
//   RESET            in   asynchronous, active-high
//   REQ0/REQ1        in   command request, held until ACK
//   RS0/RS1          in   register select of the pending command (1 = data)
//   DATA0/DATA1      in   byte of the pending command
//   ACK0/ACK1        out  one-cycle pulse: command latched this cycle
//   BUSY             out  not in IDLE, or init not yet complete
//   INIT_DONE        out  init sequence finished
//   LCD_EN           out  LCD enable strobe (registered)
//   LCD_RS           out  LCD register select (latched command)
//   LCD_RW           out  constant 0, write-only
//   LCD_DATA         out  LCD data bus (latched command)
// ---------------------------------------------------------------------------
module lcd_arbiter #(
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 12,
    parameter int T_SHORT   = 2000,
    parameter int T_LONG    = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       RS0,
    input  logic       RS1,
    input  logic [7:0] DATA0,
    input  logic [7:0] DATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    // One shared down-counter. It is wide enough for the longest interval
    // and never narrower than 17 bits.
    localparam int T_MAX0 = (T_POWERUP > T_LONG) ? T_POWERUP : T_LONG;
    localparam int T_MAX  = (T_MAX0 > T_SHORT) ? T_MAX0 : T_SHORT;
    localparam int CNT_W  = ($clog2(T_MAX + 1) > 17) ? $clog2(T_MAX + 1) : 17;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } state_t;

`ifdef LCD_ARB_AUTO_INIT_EN
    localparam state_t           RESET_STATE = ST_PWRUP;
    localparam logic [CNT_W-1:0] CNT_RESET   = CNT_W'(T_POWERUP - 1);
`else
    localparam state_t           RESET_STATE = ST_IDLE;
    localparam logic [CNT_W-1:0] CNT_RESET   = '0;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_load;
    logic             grant0;
    logic             grant1;
    logic             last_grant;   // 1: requester 1 was granted most recently
    logic             init_done;
    logic             long_wait;

    // Clear (0x01) and home (0x02/0x03) are the only instructions with
    // DATA[7:2] == 0. They need the long busy-wait.
    assign long_wait = !LCD_RS && (LCD_DATA[7:2] == 6'd0);

`ifdef LCD_ARB_AUTO_INIT_EN
    logic [1:0] init_idx;
    logic [7:0] init_byte;

    always_comb begin
        case (init_idx)
            2'd0:    init_byte = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    init_byte = 8'h0C;   // display on, cursor off
            2'd2:    init_byte = 8'h01;   // clear display
            default: init_byte = 8'h06;   // entry mode: increment, no shift
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            init_idx  <= 2'd0;
            init_done <= 1'b0;
        end else if (state == ST_WAIT && cnt == '0 && !init_done) begin
            if (init_idx == 2'd3) init_done <= 1'b1;
            else                  init_idx  <= init_idx + 2'd1;
        end
    end
`else
    assign init_done = 1'b1;
`endif

    // Next-state logic. Every timed state reloads the counter with
    // (interval - 1) on entry and leaves when the counter reaches zero.
    // That makes each state last exactly its interval.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        case (state)
`ifdef LCD_ARB_AUTO_INIT_EN
            ST_PWRUP: begin
                if (cnt == '0) state_next = ST_INIT;
            end
            ST_INIT: begin
                state_next   = ST_SETUP;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(T_SETUP - 1);
            end
`endif
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie, grant the requester that was not served last.
                    grant1       = REQ1 && (!REQ0 || !last_grant);
                    grant0       = REQ0 && !grant1;
                    state_next   = ST_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next   = ST_PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T_PULSE - 1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next   = ST_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = long_wait ? CNT_W'(T_LONG - 1)
                                             : CNT_W'(T_SHORT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
`ifdef LCD_ARB_AUTO_INIT_EN
                    if (!init_done && init_idx != 2'd3) state_next = ST_INIT;
`endif
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= RESET_STATE;
            cnt        <= CNT_RESET;
            last_grant <= 1'b1;
            LCD_EN     <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
        end else begin
            state <= state_next;
            if (cnt_load)        cnt <= cnt_load_val;
            else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
            // EN is registered from the next state. It is therefore
            // glitch-free, high for exactly the PULSE cycles, and cleared
            // at once by RESET.
            LCD_EN <= (state_next == ST_PULSE);
            if (grant0) begin
                LCD_RS     <= RS0;
                LCD_DATA   <= DATA0;
                last_grant <= 1'b0;
            end else if (grant1) begin
                LCD_RS     <= RS1;
                LCD_DATA   <= DATA1;
                last_grant <= 1'b1;
`ifdef LCD_ARB_AUTO_INIT_EN
            end else if (state == ST_INIT) begin
                LCD_RS   <= 1'b0;
                LCD_DATA <= init_byte;
`endif
            end
        end
    end

    // ACK is asserted during the IDLE cycle in which the command is latched.
    // It is gated so that no acknowledge can appear while RESET is held.
    assign ACK0      = grant0 & ~RESET;
    assign ACK1      = grant1 & ~RESET;
    assign BUSY      = (state != ST_IDLE) | ~init_done;
    assign INIT_DONE = init_done;
    assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_arbiter
//
// Self-checking bench for lcd_arbiter. Small timing values keep the runs
// short. Expected commands (RS, DATA, busy-wait length, requester) are
// pushed to a queue when stimulus is issued. A negedge monitor pops and
// compares each one as the LCD bus shows it. Expected acknowledge order is
// kept in a second queue. Build with or without LCD_ARB_AUTO_INIT_EN.
// ---------------------------------------------------------------------------
module tb_lcd_arbiter;

    localparam int T_SETUP   = 2;
    localparam int T_PULSE   = 3;
    localparam int T_SHORT   = 5;
    localparam int T_LONG    = 20;
    localparam int T_POWERUP = 10;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       REQ0     = 1'b0;
    logic       REQ1     = 1'b0;
    logic       RS0      = 1'b0;
    logic       RS1      = 1'b0;
    logic [7:0] DATA0    = 8'h00;
    logic [7:0] DATA1    = 8'h00;
    logic       ACK0, ACK1, BUSY, INIT_DONE, LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    lcd_arbiter #(
        .T_SETUP  (T_SETUP),
        .T_PULSE  (T_PULSE),
        .T_SHORT  (T_SHORT),
        .T_LONG   (T_LONG),
        .T_POWERUP(T_POWERUP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .REQ0     (REQ0),
        .REQ1     (REQ1),
        .RS0      (RS0),
        .RS1      (RS1),
        .DATA0    (DATA0),
        .DATA1    (DATA1),
        .ACK0     (ACK0),
        .ACK1     (ACK1),
        .BUSY     (BUSY),
        .INIT_DONE(INIT_DONE),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_DATA (LCD_DATA)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wait_c;
        int         req;     // -1 for an init command (no ACK expected)
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];

    int n_checks = 0;
    int n_errors = 0;

`ifdef LCD_ARB_AUTO_INIT_EN
    localparam bit AUTO_INIT = 1'b1;
`else
    localparam bit AUTO_INIT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic void push_cmd(input logic rs, input logic [7:0] data,
                                     input int wait_c, input int req);
        exp_t e;
        e.rs = rs; e.data = data; e.wait_c = wait_c; e.req = req;
        exp_q.push_back(e);
        if (req >= 0) ack_q.push_back(req);
    endfunction

    function automatic void push_init();
        push_cmd(1'b0, 8'h38, T_SHORT, -1);
        push_cmd(1'b0, 8'h0C, T_SHORT, -1);
        push_cmd(1'b0, 8'h01, T_LONG,  -1);
        push_cmd(1'b0, 8'h06, T_SHORT, -1);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   cyc = 0;
    int   t_ack = 0, t_rise = 0, t_fall = 0;
    logic en_d = 1'b0, ack_d = 1'b0;
    bit   in_wait = 1'b0;

    task automatic close_wait(input int w);
        in_wait = 1'b0;
        if (exp_q.size() != 0) begin
            check("wait_len", w, exp_q[0].wait_c);
            void'(exp_q.pop_front());
        end
    endtask

    always @(negedge CLOCK_50) begin
        cyc++;
        if (RESET) begin
            en_d = 1'b0; ack_d = 1'b0; in_wait = 1'b0;
        end else begin
            if (ACK0 || ACK1) begin
                check("ack_onehot", ACK0 & ACK1, 0);
                check("ack_1cyc", ack_d, 0);
                check("ack_expected", ack_q.size() != 0, 1);
                if (ack_q.size() != 0) check("ack_who", ACK1 ? 1 : 0, ack_q.pop_front());
                t_ack = cyc;
            end
            ack_d = ACK0 | ACK1;
            if (LCD_EN && !en_d) begin
                // For init commands the wait ends in INIT, which is followed by SETUP.
                if (in_wait) close_wait(cyc - t_fall - (T_SETUP + 1));
                check("cmd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("lcd_rs", LCD_RS, exp_q[0].rs);
                    check("lcd_data", LCD_DATA, exp_q[0].data);
                    if (exp_q[0].req >= 0) check("ack_to_en", cyc - t_ack, T_SETUP + 1);
                end
                t_rise = cyc;
            end else if (!LCD_EN && en_d) begin
                check("pulse_len", cyc - t_rise, T_PULSE);
                if (exp_q.size() != 0) check("data_hold", LCD_DATA, exp_q[0].data);
                t_fall  = cyc;
                in_wait = 1'b1;
            end
            if (in_wait && !BUSY) close_wait(cyc - t_fall);
            en_d = LCD_EN;
        end
    end

    // ---------------- drivers ----------------
    // Call with inputs aligned just after a posedge. Returns after the ACK
    // edge, optionally dropping REQ. n is the number of negedges to ACK.
    task automatic send(input int id, input logic rs, input logic [7:0] data,
                        input bit drop, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        if (id == 0) begin REQ0 = 1'b1; RS0 = rs; DATA0 = data; end
        else         begin REQ1 = 1'b1; RS1 = rs; DATA1 = data; end
        while (!seen && n < 400) begin
            @(negedge CLOCK_50);
            n++;
            seen = (id == 0) ? ACK0 : ACK1;
        end
        check((id == 0) ? "ack0_seen" : "ack1_seen", seen, 1);
        @(posedge CLOCK_50); #1;
        if (drop || !seen) begin
            if (id == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || BUSY) && n < 600) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("drain_empty", exp_q.size() + ack_q.size(), 0);
        @(posedge CLOCK_50); #1;
    endtask

    task automatic check_reset_state();
        check("rst_en", LCD_EN, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_rw", LCD_RW, 0);
        check("rst_ack", {ACK0, ACK1}, 2'b00);
        check("rst_busy", BUSY, AUTO_INIT ? 1 : 0);
        check("rst_init_done", INIT_DONE, AUTO_INIT ? 0 : 1);
    endtask

    // Releases reset. With auto-init, also checks power-up latency and the
    // init sequence.
    task automatic release_reset();
        int n;
        if (AUTO_INIT) push_init();
        @(posedge CLOCK_50); #1;
        RESET = 1'b0;
        if (AUTO_INIT) begin
            n = 0;
            while (!LCD_EN && n < 200) begin
                @(negedge CLOCK_50);
                n++;
            end
            check("pwrup_to_en", n, T_POWERUP + 1 + T_SETUP);
            drain();
        end else begin
            #1;
            check("noinit_busy", BUSY, 0);
        end
        check("init_done", INIT_DONE, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, n1;
        repeat (3) @(negedge CLOCK_50);
        check_reset_state();
        release_reset();

        // Single data write from requester 0; it is acknowledged in the first IDLE cycle.
        push_cmd(1'b1, 8'h41, T_SHORT, 0);
        send(0, 1'b1, 8'h41, 1'b1, n);
        check("ack_first_idle", n, 1);
        drain();

        // Home: long wait. Set DDRAM address: short wait.
        push_cmd(1'b0, 8'h02, T_LONG, 1);
        send(1, 1'b0, 8'h02, 1'b1, n);
        drain();
        push_cmd(1'b0, 8'h80, T_SHORT, 1);
        send(1, 1'b0, 8'h80, 1'b1, n);
        drain();

        // Both requesters hold REQ continuously: grants alternate, starting with 0.
        push_cmd(1'b1, 8'h30, T_SHORT, 0);
        push_cmd(1'b1, 8'h50, T_SHORT, 1);
        push_cmd(1'b1, 8'h31, T_SHORT, 0);
        push_cmd(1'b1, 8'h51, T_SHORT, 1);
        fork
            begin
                send(0, 1'b1, 8'h30, 1'b0, n0);
                send(0, 1'b1, 8'h31, 1'b1, n0);
            end
            begin
                send(1, 1'b1, 8'h50, 1'b0, n1);
                send(1, 1'b1, 8'h51, 1'b1, n1);
            end
        join
        drain();

        // Reset in the middle of an enable pulse.
        push_cmd(1'b1, 8'h55, T_SHORT, 0);
        send(0, 1'b1, 8'h55, 1'b1, n);
        n = 0;
        while (!LCD_EN && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("midpulse_en_seen", LCD_EN, 1);
        @(posedge CLOCK_50); #1;
        RESET = 1'b1;
        #1;
        check("midpulse_en_low", LCD_EN, 0);
        exp_q.delete();
        ack_q.delete();
        repeat (2) @(negedge CLOCK_50);
        check_reset_state();
        release_reset();

        // Normal operation after the re-initialisation.
        push_cmd(1'b1, 8'h42, T_SHORT, 1);
        send(1, 1'b1, 8'h42, 1'b1, n);
        check("ack_after_reinit", n, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
